// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares one combinational program-memory port between instruction fetch and debug reads.
// Define PM_ARB_ROUND_ROBIN_EN for alternating grants under contention; the default build gives fetch fixed priority.
module program_memory_arbiter #(
    parameter int MEMORY_DEPTH = 'h200,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Fetch_Req,
    input  logic [DATA_WIDTH-1:0] Fetch_Addr,
    output logic                  Fetch_Gnt,
    output logic                  Fetch_Valid,
    output logic [DATA_WIDTH-1:0] Fetch_Data,
    output logic                  Fetch_Err,
    input  logic                  Dbg_Req,
    input  logic [DATA_WIDTH-1:0] Dbg_Addr,
    output logic                  Dbg_Gnt,
    output logic                  Dbg_Valid,
    output logic [DATA_WIDTH-1:0] Dbg_Data,
    output logic                  Dbg_Err,
    output logic [DATA_WIDTH-1:0] Mem_Address,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction,
    output logic [15:0]           Dbg_Wait_Cnt
);

    typedef enum logic {LAST_FETCH, LAST_DBG} arb_state_t;

    arb_state_t            state;
    logic                  pick_dbg;
    logic                  fetch_bad;
    logic                  dbg_bad;
    logic [DATA_WIDTH-1:0] addr_q;

    // Addresses below TEXT_BASE wrap to huge offsets and so fail the depth test.
    function automatic logic addr_err(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] off;
        off = a - TEXT_BASE;
        return (off[1:0] != 2'b00) || ((off >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
    endfunction

`ifdef PM_ARB_ROUND_ROBIN_EN
    assign pick_dbg = (state == LAST_FETCH);
`else
    assign pick_dbg = 1'b0;
`endif

    assign Fetch_Gnt   = !reset && Fetch_Req && !(Dbg_Req && pick_dbg);
    assign Dbg_Gnt     = !reset && Dbg_Req && !(Fetch_Req && !pick_dbg);
    assign Mem_Address = Fetch_Gnt ? Fetch_Addr : Dbg_Gnt ? Dbg_Addr : addr_q;
    assign fetch_bad   = addr_err(Fetch_Addr);
    assign dbg_bad     = addr_err(Dbg_Addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LAST_DBG;
            addr_q       <= TEXT_BASE;
            Fetch_Valid  <= 1'b0;
            Fetch_Err    <= 1'b0;
            Fetch_Data   <= '0;
            Dbg_Valid    <= 1'b0;
            Dbg_Err      <= 1'b0;
            Dbg_Data     <= '0;
            Dbg_Wait_Cnt <= '0;
        end else begin
            state        <= Fetch_Gnt ? LAST_FETCH : Dbg_Gnt ? LAST_DBG : state;
            addr_q       <= Mem_Address;
            Fetch_Valid  <= Fetch_Gnt;
            Fetch_Err    <= Fetch_Gnt && fetch_bad;
            Fetch_Data   <= Fetch_Gnt ? (fetch_bad ? '0 : Mem_Instruction) : Fetch_Data;
            Dbg_Valid    <= Dbg_Gnt;
            Dbg_Err      <= Dbg_Gnt && dbg_bad;
            Dbg_Data     <= Dbg_Gnt ? (dbg_bad ? '0 : Mem_Instruction) : Dbg_Data;
            Dbg_Wait_Cnt <= Dbg_Gnt ? 16'd0 :
                            (Dbg_Req && Dbg_Wait_Cnt != 16'hFFFF) ? Dbg_Wait_Cnt + 16'd1 : Dbg_Wait_Cnt;
        end
    end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb_program_memory_arbiter: directed checks of grants, responses, range errors, wait counter and reset.
module tb_program_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Fetch_Req = 1'b0;
    logic [31:0] Fetch_Addr = 32'h0;
    logic        Fetch_Gnt, Fetch_Valid, Fetch_Err;
    logic [31:0] Fetch_Data;
    logic        Dbg_Req = 1'b0;
    logic [31:0] Dbg_Addr = 32'h0;
    logic        Dbg_Gnt, Dbg_Valid, Dbg_Err;
    logic [31:0] Dbg_Data;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Instruction;
    logic [15:0] Dbg_Wait_Cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Word 1 holds the known instruction; every other word reads back as the inverted address.
    assign Mem_Instruction = (Mem_Address == 32'h0040_0004) ? 32'h2008_0005 : ~Mem_Address;

    program_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .Fetch_Req(Fetch_Req), .Fetch_Addr(Fetch_Addr), .Fetch_Gnt(Fetch_Gnt),
        .Fetch_Valid(Fetch_Valid), .Fetch_Data(Fetch_Data), .Fetch_Err(Fetch_Err),
        .Dbg_Req(Dbg_Req), .Dbg_Addr(Dbg_Addr), .Dbg_Gnt(Dbg_Gnt),
        .Dbg_Valid(Dbg_Valid), .Dbg_Data(Dbg_Data), .Dbg_Err(Dbg_Err),
        .Mem_Address(Mem_Address), .Mem_Instruction(Mem_Instruction),
        .Dbg_Wait_Cnt(Dbg_Wait_Cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] err_addr [3] = '{32'h0040_0800, 32'h003F_FFFC, 32'h0040_0002};
    logic [3:0]  exp_fg;
    logic [15:0] exp_cnt [4];

    initial begin
        // Requests during reset must not be granted.
        Fetch_Req = 1'b1; Fetch_Addr = 32'h0040_0004;
        step(); step();
        chk("rst_fgnt", Fetch_Gnt, 0);
        chk("rst_maddr", Mem_Address, 32'h0040_0000);
        chk("rst_fvalid", Fetch_Valid, 0);
        chk("rst_fdata", Fetch_Data, 0);
        chk("rst_cnt", Dbg_Wait_Cnt, 0);
        reset = 1'b0; Fetch_Req = 1'b0;
        step();
        chk("idle_fvalid", Fetch_Valid, 0);

        // Single fetch of word 1.
        Fetch_Req = 1'b1; Fetch_Addr = 32'h0040_0004;
        #1;
        chk("f1_gnt", Fetch_Gnt, 1);
        chk("f1_dgnt", Dbg_Gnt, 0);
        chk("f1_maddr", Mem_Address, 32'h0040_0004);
        step();
        Fetch_Req = 1'b0;
        chk("f1_valid", Fetch_Valid, 1);
        chk("f1_data", Fetch_Data, 32'h2008_0005);
        chk("f1_err", Fetch_Err, 0);
        step();
        chk("f1_valid_off", Fetch_Valid, 0);
        chk("hold_maddr", Mem_Address, 32'h0040_0004);

        // Debug range errors: past end, below base, misaligned.
        for (int i = 0; i < 3; i++) begin
            Dbg_Req = 1'b1; Dbg_Addr = err_addr[i];
            #1;
            chk($sformatf("e%0d_gnt", i), Dbg_Gnt, 1);
            step();
            Dbg_Req = 1'b0;
            chk($sformatf("e%0d_valid", i), Dbg_Valid, 1);
            chk($sformatf("e%0d_err", i), Dbg_Err, 1);
            chk($sformatf("e%0d_data", i), Dbg_Data, 0);
            step();
            chk($sformatf("e%0d_valid_off", i), Dbg_Valid, 0);
            chk($sformatf("e%0d_err_off", i), Dbg_Err, 0);
        end

        // Last valid word reads normally.
        Dbg_Req = 1'b1; Dbg_Addr = 32'h0040_07FC;
        step();
        Dbg_Req = 1'b0;
        chk("last_valid", Dbg_Valid, 1);
        chk("last_err", Dbg_Err, 0);
        chk("last_data", Dbg_Data, 32'hFFBF_F803);

        // Contention for 4 cycles; last grant so far was debug.
`ifdef PM_ARB_ROUND_ROBIN_EN
        exp_fg = 4'b0101;
        exp_cnt = '{16'd0, 16'd1, 16'd0, 16'd1};
`else
        exp_fg = 4'b1111;
        exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3};
`endif
        Fetch_Req = 1'b1; Fetch_Addr = 32'h0040_0010;
        Dbg_Req = 1'b1; Dbg_Addr = 32'h0040_0020;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("c%0d_fgnt", i), Fetch_Gnt, exp_fg[i]);
            chk($sformatf("c%0d_dgnt", i), Dbg_Gnt, !exp_fg[i]);
            chk($sformatf("c%0d_cnt", i), Dbg_Wait_Cnt, exp_cnt[i]);
            step();
        end
        Fetch_Req = 1'b0; Dbg_Req = 1'b0;
`ifdef PM_ARB_ROUND_ROBIN_EN
        chk("c_cnt_end", Dbg_Wait_Cnt, 0);
        chk("c_dvalid", Dbg_Valid, 1);
        chk("c_ddata", Dbg_Data, 32'hFFBF_FFDF);
`else
        chk("c_cnt_end", Dbg_Wait_Cnt, 4);
        chk("c_fvalid", Fetch_Valid, 1);
        chk("c_fdata", Fetch_Data, 32'hFFBF_FFEF);
        step();
        chk("c_dvalid_drop", Dbg_Valid, 0);
        chk("c_cnt_hold", Dbg_Wait_Cnt, 4);

        // Long starvation saturates the wait counter.
        Fetch_Req = 1'b1; Dbg_Req = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", Dbg_Wait_Cnt, 32'h0000_FFFF);
        step();
        chk("sat_hold", Dbg_Wait_Cnt, 32'h0000_FFFF);
        Fetch_Req = 1'b0;
        #1;
        chk("sat_dgnt", Dbg_Gnt, 1);
        step();
        Dbg_Req = 1'b0;
        chk("sat_cnt_clr", Dbg_Wait_Cnt, 0);
        chk("sat_dvalid", Dbg_Valid, 1);
`endif

        // Reset in the middle of a response clears everything at once.
        Fetch_Req = 1'b1; Fetch_Addr = 32'h0040_0004;
        step();
        chk("mr_pre_valid", Fetch_Valid, 1);
        reset = 1'b1;
        #1;
        chk("mr_fvalid", Fetch_Valid, 0);
        chk("mr_fdata", Fetch_Data, 0);
        chk("mr_fgnt", Fetch_Gnt, 0);
        chk("mr_maddr", Mem_Address, 32'h0040_0000);
        step();
        chk("mr_novalid", Fetch_Valid, 0);
        reset = 1'b0;
        Dbg_Req = 1'b1; Dbg_Addr = 32'h0040_0020;
        #1;
        chk("post_fgnt", Fetch_Gnt, 1);
        chk("post_dgnt", Dbg_Gnt, 0);
        step();
        Fetch_Req = 1'b0; Dbg_Req = 1'b0;
        chk("post_fvalid", Fetch_Valid, 1);
        chk("post_cnt", Dbg_Wait_Cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_memory_arbiter.md
PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): MEMORY_DEPTH, 'h200, program memory words; DATA_WIDTH, 32, address/data width; TEXT_BASE, 32'h0040_0000, byte address of program memory word 0.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first; one clock, reset asynchronous active-high:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
Fetch_Req  input  1  instruction fetch request
Fetch_Addr  input  DATA_WIDTH  fetch byte address
Fetch_Gnt  output  1  fetch request accepted this cycle
Fetch_Valid  output  1  fetch response valid
Fetch_Data  output  DATA_WIDTH  fetch response word
Fetch_Err  output  1  fetch address out of range/misaligned
Dbg_Req  input  1  debug/loader read request
Dbg_Addr  input  DATA_WIDTH  debug byte address
Dbg_Gnt  output  1  debug request accepted this cycle
Dbg_Valid  output  1  debug response valid
Dbg_Data  output  DATA_WIDTH  debug response word
Dbg_Err  output  1  debug address out of range/misaligned
Mem_Address  output  DATA_WIDTH  byte address to program memory
Mem_Instruction  input  DATA_WIDTH  combinational read data from program memory
Dbg_Wait_Cnt  output  16  saturating count of cycles Dbg_Req was high and not granted

Function
REQ-003 SHALL grant at most one requester per cycle; Fetch_Gnt and Dbg_Gnt are combinational from Req inputs and arbitration state, never both 1.
REQ-004 Requester SHALL hold Req and Addr stable until Gnt; block SHALL tolerate Req deassertion before Gnt (request dropped, no response).
REQ-005 Mem_Address SHALL equal granted requester's Addr; with no grant, SHALL hold last driven value.
REQ-006 On grant edge, Mem_Instruction SHALL be captured into the granted requester's Data register; that requester's Valid SHALL be 1 for exactly the next cycle (latency 1, throughput 1 request/cycle).
REQ-007 Range check: offset = Addr - TEXT_BASE (DATA_WIDTH-bit wrap-around subtraction); Err SHALL be 1 if offset[1:0]!=0 or offset[DATA_WIDTH-1:2] >= MEMORY_DEPTH, including Addr below TEXT_BASE.
REQ-008 On Err, Data SHALL be 0, Valid SHALL still pulse 1 with Err 1 in the same cycle; Err SHALL be 0 whenever Valid is 0.
REQ-009 Arbitration state SHALL be a 2-state FSM LAST_FETCH/LAST_DBG, recording the last granted requester; SHALL update only on a grant; no grant leaves state unchanged.
REQ-010 Single requester active SHALL be granted immediately regardless of FSM state.
REQ-011 Dbg_Wait_Cnt SHALL increment by 1 each cycle Dbg_Req=1 and Dbg_Gnt=0, saturate at 16'hFFFF, reset to 0 on the cycle Dbg_Gnt=1 (next value 0).
REQ-012 Valid outputs SHALL be 0 in any cycle following a cycle with no grant for that requester.

Reset
REQ-013 reset=1 SHALL asynchronously force: FSM=LAST_DBG, Fetch_Valid=Dbg_Valid=0, Fetch_Err=Dbg_Err=0, Fetch_Data=Dbg_Data=0, Mem_Address=TEXT_BASE, Dbg_Wait_Cnt=0.
REQ-014 Gnt outputs SHALL be 0 while reset=1; a request granted in the cycle reset asserts SHALL produce no response.
REQ-015 First rising edge after reset deassertion SHALL be a normal arbitration cycle.

Configuration
REQ-016 Macro PM_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL be granted to the requester other than FSM's last granted (alternating).
REQ-017 Macro PM_ARB_ROUND_ROBIN_EN undefined: simultaneous requests SHALL always grant Fetch (fixed priority); FSM and Dbg_Wait_Cnt still maintained.

Verification
REQ-018 Reset, then Fetch_Req=1, Fetch_Addr=32'h0040_0004, memory word1=32'h2008_0005 -> Fetch_Gnt=1 same cycle, Fetch_Valid=1, Fetch_Data=32'h2008_0005, Fetch_Err=0 next cycle.
REQ-019 Dbg_Addr=32'h0040_0800 (word 'h200) and separately 32'h003F_FFFC and 32'h0040_0002 -> Dbg_Valid=1, Dbg_Err=1, Dbg_Data=0 for each.
REQ-020 Both Req held 1 for 4 cycles, ROUND_ROBIN_EN defined, after reset -> grants Fetch,Dbg,Fetch,Dbg; Dbg_Wait_Cnt 0,1,0,1 sequence.
REQ-021 Both Req held 1 for 4 cycles, macro undefined -> Fetch granted all 4 cycles, Dbg_Wait_Cnt=4 after.
REQ-022 Dbg_Req=1 blocked for 70000 cycles (macro undefined, Fetch_Req=1) -> Dbg_Wait_Cnt holds 16'hFFFF; drop Fetch_Req -> Dbg_Gnt=1, counter 0 next cycle; reset asserted mid-transfer -> all outputs per REQ-013 immediately, no Valid pulse.
